wdt32_core: RTL and testbench
=============================

# wdt32_core

Watchdog timer core behind the 32-bit APB watchdog register wrapper on the APB peripheral subsystem. Consumes the wrapper's WDLOAD, WDEN and WDOVCLR register outputs and returns the live count (WDTMR) and a sticky overflow flag (WDOV). WDOV drives the wrapper's status register and its IRQ gating. The core is a prescaled 32-bit down-counter with a small state machine, edge-detected control, and reload-on-kick.

## Interface

Parameters:
- PRESCALE, default 1: count tick every PRESCALE clk cycles; legal range 1..65536.
- PRE_W, default 16: prescaler counter width; must hold PRESCALE-1.

Ports:
- clk  in  1  system clock, the APB PCLK domain. One clock only.
- rst  in  1  reset, asynchronous, active-high.
- WDLOAD  in  32  reload value, from the wrapper register.
- WDEN  in  1  enable level, from the wrapper register.
- WDOVCLR  in  1  clear/kick level, from the wrapper register. Acts on its rising edge.
- WDTMR  out  32  current count; registered.
- WDOV  out  1  sticky overflow flag; registered.

## Operation

- States:
  - IDLE: counter frozen.
  - COUNT: counter decrementing.
- Reset: state IDLE, WDTMR=0, WDOV=0, prescaler=0, en_q=0, clr_q=0.
- Edge detection:
  - en_q and clr_q are registered copies of WDEN and WDOVCLR.
  - en_rise = WDEN & ~en_q.
  - clr_rise = WDOVCLR & ~clr_q.
- IDLE -> COUNT on en_rise:
  - WDTMR <= WDLOAD, prescaler <= 0.
  - WDOV is unchanged.
- COUNT -> IDLE when WDEN=0:
  - WDTMR holds its last value; prescaler <= 0.
  - WDOV is unchanged.
- Tick in COUNT: asserted when prescaler == PRESCALE-1. The prescaler wraps to 0 on a tick and increments otherwise.
- On tick:
  - If WDTMR != 0: WDTMR <= WDTMR-1.
  - If WDTMR == 0: WDOV <= 1 and WDTMR <= WDLOAD (periodic auto-reload).
- Kick, when clr_rise occurs in COUNT:
  - WDOV <= 0, WDTMR <= WDLOAD, prescaler <= 0.
- clr_rise in IDLE: WDOV <= 0 only; WDTMR is unchanged.
- Priority within one cycle, highest first:
  1. rst
  2. WDEN=0 (to IDLE). A clr_rise in the same cycle still clears WDOV.
  3. clr_rise
  4. tick
- Consequence of that priority: when a kick and an expiry coincide, the kick wins. WDOV ends 0 and WDTMR ends = WDLOAD.
- WDLOAD=0: every tick is an expiry, so WDOV sets on the first tick and WDTMR stays 0.
- WDLOAD = 32'hFFFFFFFF is legal. The decrement is plain 32-bit unsigned; there is no underflow path because 0 always reloads.
- A WDLOAD change while counting does not affect WDTMR until the next reload (expiry, kick or re-enable).
- WDOVCLR held high gives one kick only. Software must write 0, then 1 to kick again.

## Timing

- All outputs are registered with no combinational input-to-output path.
- WDEN 0->1 sampled at edge N: WDTMR = WDLOAD after edge N.
- Countdown cadence with PRESCALE=1:
  - WDTMR decrements after each edge N+1 ... N+WDLOAD.
  - It reaches 0 after edge N+WDLOAD.
  - WDOV=1 and WDTMR=WDLOAD after edge N+WDLOAD+1.
  - Overflow period = (WDLOAD+1)·PRESCALE cycles.
- Kick: WDOVCLR rising sampled at edge K gives WDOV=0 and WDTMR=WDLOAD after edge K. The next decrement is at edge K+PRESCALE.
- rst asserted mid-count: all state returns to reset values immediately (asynchronous). Counting resumes only on a fresh WDEN rising edge after rst deasserts; a WDEN already high at deassert does not count as a rising edge.
- Throughput: one tick per PRESCALE cycles, no stalls.

## Test plan

- Basic count, PRESCALE=1: WDLOAD=5, WDEN 0->1 at edge 0 -> WDTMR sequence 5,4,3,2,1,0; at edge 6 WDOV=1 and WDTMR=5; second expiry at edge 12.
- Prescale, PRESCALE=4: WDLOAD=2, enable -> WDTMR changes only every 4 cycles; WDOV rises 12 cycles after enable.
- Kick, PRESCALE=1: WDLOAD=10, enable, WDOVCLR 0->1 when WDTMR=3 -> WDTMR=10 the next cycle and WDOV stays 0. Holding WDOVCLR=1 causes no further reloads.
- Simultaneous kick/expiry, PRESCALE=1: WDLOAD=4, WDOVCLR rising in the same cycle as the WDTMR=0 tick -> WDOV=0 and WDTMR=4.
- Disable/re-enable and reset:
  - WDEN->0 at WDTMR=7 -> WDTMR holds 7 and WDOV is retained.
  - WDEN->1 -> WDTMR reloads WDLOAD.
  - rst pulse mid-count -> WDTMR=0 and WDOV=0 immediately; no counting until a new WDEN rising edge.
- Edge values:
  - WDLOAD=0 -> WDOV=1 one tick after enable, WDTMR stays 0.
  - WDLOAD=32'hFFFFFFFF -> first tick gives 32'hFFFFFFFE.

Source files
------------

// File: rtl/wdt32_core.sv
// Prescaled 32-bit watchdog down-counter with sticky overflow.
// Reloads on enable, expiry or kick; control inputs act on rising edges.
module wdt32_core #(
  parameter int PRESCALE = 1,
  parameter int PRE_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] WDLOAD,
  input  logic        WDEN,
  input  logic        WDOVCLR,
  output logic [31:0] WDTMR,
  output logic        WDOV
);

  typedef enum logic {
    IDLE,
    COUNT
  } state_t;

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  state_t             state, state_n;
  logic [PRE_W-1:0]   pre, pre_n;
  logic [31:0]        tmr_n;
  logic               ov_n;
  logic               en_q, clr_q, en_blk;
  logic               en_rise, clr_rise, tick;

  // en_blk masks a WDEN that is already high when reset releases
  assign en_rise  = WDEN & ~en_q & ~en_blk;
  assign clr_rise = WDOVCLR & ~clr_q;
  assign tick     = (pre == PRE_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      WDTMR  <= '0;
      WDOV   <= 1'b0;
      pre    <= '0;
      en_q   <= 1'b0;
      clr_q  <= 1'b0;
      en_blk <= 1'b1;
    end else begin
      state  <= state_n;
      WDTMR  <= tmr_n;
      WDOV   <= ov_n;
      pre    <= pre_n;
      en_q   <= WDEN;
      clr_q  <= WDOVCLR;
      en_blk <= en_blk & WDEN;
    end
  end

  always_comb begin
    state_n = state;
    tmr_n   = WDTMR;
    ov_n    = WDOV;
    pre_n   = pre;
    case (state)
      IDLE: begin
        if (clr_rise) ov_n = 1'b0;
        if (en_rise) begin
          state_n = COUNT;
          tmr_n   = WDLOAD;
          pre_n   = '0;
        end
      end
      COUNT: begin
        if (!WDEN) begin
          state_n = IDLE;
          pre_n   = '0;
          if (clr_rise) ov_n = 1'b0;
        end else if (clr_rise) begin
          ov_n  = 1'b0;
          tmr_n = WDLOAD;
          pre_n = '0;
        end else if (tick) begin
          pre_n = '0;
          if (WDTMR == 32'd0) begin
            ov_n  = 1'b1;
            tmr_n = WDLOAD;
          end else begin
            tmr_n = WDTMR - 32'd1;
          end
        end else begin
          pre_n = pre + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wdt32_core.sv
// Bench for wdt32_core: directed plan steps plus random control traffic,
// two instances (PRESCALE 1 and 4) checked against a cycle model.
module tb_wdt32_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] WDLOAD;
  logic        WDEN;
  logic        WDOVCLR;
  logic [31:0] tmr1, tmr4;
  logic        ov1, ov4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wdt32_core #(.PRESCALE(1), .PRE_W(16)) dut1 (
    .clk(clk), .rst(rst), .WDLOAD(WDLOAD), .WDEN(WDEN),
    .WDOVCLR(WDOVCLR), .WDTMR(tmr1), .WDOV(ov1)
  );

  wdt32_core #(.PRESCALE(4), .PRE_W(16)) dut4 (
    .clk(clk), .rst(rst), .WDLOAD(WDLOAD), .WDEN(WDEN),
    .WDOVCLR(WDOVCLR), .WDTMR(tmr4), .WDOV(ov4)
  );

  // Reference model: running flag, count, flag, cycles since last reload
  int unsigned pval [2] = '{1, 4};
  bit          m_run [2];
  logic [31:0] m_cnt [2];
  logic        m_ov  [2];
  int unsigned m_ph  [2];
  bit          m_en_prev, m_clr_prev, m_armed;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 1'b0;
      m_cnt[i] = '0;
      m_ov[i]  = 1'b0;
      m_ph[i]  = 0;
    end
    m_en_prev  = 1'b0;
    m_clr_prev = 1'b0;
    m_armed    = 1'b0;
  endtask

  task automatic model_step();
    bit ren, rclr;
    ren  = WDEN && !m_en_prev && m_armed;
    rclr = WDOVCLR && !m_clr_prev;
    for (int i = 0; i < 2; i++) begin
      if (!m_run[i]) begin
        if (rclr) m_ov[i] = 1'b0;
        if (ren) begin
          m_run[i] = 1'b1;
          m_cnt[i] = WDLOAD;
          m_ph[i]  = 0;
        end
      end else if (!WDEN) begin
        m_run[i] = 1'b0;
        if (rclr) m_ov[i] = 1'b0;
      end else if (rclr) begin
        m_ov[i]  = 1'b0;
        m_cnt[i] = WDLOAD;
        m_ph[i]  = 0;
      end else begin
        m_ph[i]++;
        if (m_ph[i] % pval[i] == 0) begin
          if (m_cnt[i] == 0) begin
            m_ov[i]  = 1'b1;
            m_cnt[i] = WDLOAD;
          end else begin
            m_cnt[i] = m_cnt[i] - 1;
          end
        end
      end
    end
    if (!WDEN) m_armed = 1'b1;
    m_en_prev  = WDEN;
    m_clr_prev = WDOVCLR;
  endtask

  // One clock: update model at the edge, compare 1 time unit later
  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    chk("model_tmr_p1", tmr1, m_cnt[0]);
    chk("model_ov_p1", {31'd0, ov1}, {31'd0, m_ov[0]});
    chk("model_tmr_p4", tmr4, m_cnt[1]);
    chk("model_ov_p4", {31'd0, ov4}, {31'd0, m_ov[1]});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic kick();
    WDOVCLR = 1'b1;
    cyc();
    WDOVCLR = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    WDLOAD = '0;
    WDEN = 1'b0;
    WDOVCLR = 1'b0;
    model_reset();
    #1;
    chk("reset_tmr", tmr1, 32'd0);
    chk("reset_ov", {31'd0, ov1}, 32'd0);
    cyc();
    rst = 1'b0;
    cyc();

    // Basic count, PRESCALE=1
    WDLOAD = 32'd5;
    WDEN = 1'b1;
    cyc();
    chk("basic_load", tmr1, 32'd5);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk("basic_dec", tmr1, 32'(5 - k));
      chk("basic_ov_low", {31'd0, ov1}, 32'd0);
    end
    cyc();
    chk("basic_ov_set", {31'd0, ov1}, 32'd1);
    chk("basic_reload", tmr1, 32'd5);
    run(5);
    chk("basic_zero2", tmr1, 32'd0);
    cyc();
    chk("basic_reload2", tmr1, 32'd5);

    // Prescale 4: WDOV 12 cycles after enable with WDLOAD=2
    WDEN = 1'b0;
    cyc();
    kick();
    chk("idle_clr_ov", {31'd0, ov1}, 32'd0);
    WDLOAD = 32'd2;
    cyc();
    WDEN = 1'b1;
    cyc();
    chk("pre_load", tmr4, 32'd2);
    for (int n = 1; n <= 12; n++) begin
      cyc();
      chk("pre_tmr", tmr4,
          (n < 4) ? 32'd2 : (n < 8) ? 32'd1 : (n < 12) ? 32'd0 : 32'd2);
      chk("pre_ov", {31'd0, ov4}, (n == 12) ? 32'd1 : 32'd0);
    end

    // Kick at WDTMR=3; held WDOVCLR does not reload again
    WDEN = 1'b0;
    cyc();
    kick();
    WDLOAD = 32'd10;
    cyc();
    WDEN = 1'b1;
    cyc();
    run(7);
    chk("kick_pre", tmr1, 32'd3);
    WDOVCLR = 1'b1;
    cyc();
    chk("kick_reload", tmr1, 32'd10);
    chk("kick_ov", {31'd0, ov1}, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      chk("kick_held", tmr1, 32'(10 - k));
    end
    WDOVCLR = 1'b0;

    // Kick coincides with expiry tick
    WDLOAD = 32'd4;
    cyc();
    kick();
    chk("sim_load", tmr1, 32'd4);
    run(4);
    chk("sim_zero", tmr1, 32'd0);
    WDOVCLR = 1'b1;
    cyc();
    WDOVCLR = 1'b0;
    chk("sim_ov", {31'd0, ov1}, 32'd0);
    chk("sim_tmr", tmr1, 32'd4);

    // Disable at 7 keeps count and flag; re-enable reloads
    WDLOAD = 32'd9;
    cyc();
    kick();
    run(10);
    chk("dis_ov_set", {31'd0, ov1}, 32'd1);
    run(2);
    chk("dis_pre", tmr1, 32'd7);
    WDEN = 1'b0;
    cyc();
    run(3);
    chk("dis_hold", tmr1, 32'd7);
    chk("dis_ov_kept", {31'd0, ov1}, 32'd1);
    WDEN = 1'b1;
    cyc();
    chk("reen_load", tmr1, 32'd9);

    // Asynchronous reset mid-count; high WDEN at release is not an edge
    run(3);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_tmr", tmr1, 32'd0);
    chk("arst_ov", {31'd0, ov4}, 32'd0);
    run(2);
    rst = 1'b0;
    run(3);
    chk("arst_nocount", tmr1, 32'd0);
    WDEN = 1'b0;
    cyc();
    WDEN = 1'b1;
    cyc();
    chk("arst_reen", tmr1, 32'd9);

    // WDLOAD = 0
    WDEN = 1'b0;
    WDLOAD = 32'd0;
    cyc();
    WDEN = 1'b1;
    cyc();
    chk("zero_load", tmr1, 32'd0);
    cyc();
    chk("zero_ov", {31'd0, ov1}, 32'd1);
    chk("zero_tmr", tmr1, 32'd0);

    // WDLOAD = all ones
    WDEN = 1'b0;
    WDLOAD = 32'hFFFF_FFFF;
    cyc();
    WDEN = 1'b1;
    cyc();
    chk("max_load", tmr1, 32'hFFFF_FFFF);
    cyc();
    chk("max_dec", tmr1, 32'hFFFF_FFFE);

    // Random control traffic
    WDLOAD = 32'd3;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19) == 0) WDEN = ~WDEN;
      if ($urandom_range(5) == 0) WDOVCLR = ~WDOVCLR;
      if ($urandom_range(15) == 0) begin
        if ($urandom_range(30) == 0) WDLOAD = $urandom;
        else WDLOAD = 32'($urandom_range(12));
      end
      rst = ($urandom_range(399) == 0);
      cyc();
    end
    rst = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
